// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port 16-bit SRAM arbiter.
//   state_t : word sequencing states (idle, low half, high half, ack)
//   port_t  : requester identity used for grant and round-robin history
//   byte_to_word : byte address to 32-bit SRAM word index after base offset
package sram_arb_pkg;

  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;
  // Word index width: one SRAM address bit selects the half.
  localparam int unsigned SramWordW = SramAddrW - 1;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_t;

  typedef enum logic {
    PortMem,
    PortIf
  } port_t;

  function automatic logic [SramWordW-1:0] byte_to_word(input logic [31:0] addr,
                                                        input logic [31:0] base);
    return SramWordW'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_half_seq.sv
// One 16-bit SRAM access lasting WAIT_CYCLES cycles.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           load a new access this cycle (may coincide with done_o)
//   we_i, addr_i      access direction and SRAM half-word address
//   wdata16_i         write data for the access
//   done_o            high in the last cycle of the access
//   rdata16_o         SRAM data bus; the caller samples it while done_o is high
//   sram_*_n_o        registered active-low SRAM strobes
//   sram_addr_o       registered SRAM address, held between accesses
//   dq_o, dq_oe_o     write data and its output enable
//   dq_i              SRAM data bus input
module sram_half_seq
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 we_i,
  input  logic [SramAddrW-1:0] addr_i,
  input  logic [SramDataW-1:0] wdata16_i,
  output logic                 done_o,
  output logic [SramDataW-1:0] rdata16_o,
  output logic [SramAddrW-1:0] sram_addr_o,
  output logic                 sram_ce_n_o,
  output logic                 sram_ub_n_o,
  output logic                 sram_lb_n_o,
  output logic                 sram_we_n_o,
  output logic                 sram_oe_n_o,
  output logic [SramDataW-1:0] dq_o,
  output logic                 dq_oe_o,
  input  logic [SramDataW-1:0] dq_i
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  logic                 active_q, active_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [SramAddrW-1:0] addr_q, addr_d;
  logic [SramDataW-1:0] dq_q, dq_d;
  logic                 ce_n_q, ce_n_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 dq_oe_q, dq_oe_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    dq_d     = dq_q;
    ce_n_d   = ce_n_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    dq_oe_d  = dq_oe_q;
    if (start_i) begin
      // Start wins over completion so two halves run back to back.
      active_d = 1'b1;
      cnt_d    = CntW'(WAIT_CYCLES - 1);
      addr_d   = addr_i;
      dq_d     = wdata16_i;
      ce_n_d   = 1'b0;
      we_n_d   = ~we_i;
      oe_n_d   = we_i;
      dq_oe_d  = we_i;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
        // WE_N rises for the final cycle so data/address hold past the write edge.
        if (cnt_q == CntW'(1)) we_n_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      dq_q     <= '0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      dq_q     <= dq_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign done_o      = active_q && (cnt_q == '0);
  assign rdata16_o   = dq_i;
  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_ub_n_o = ce_n_q;
  assign sram_lb_n_o = ce_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign dq_o        = dq_q;
  assign dq_oe_o     = dq_oe_q;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit external SRAM between the data port (read/write) and the instruction
// port (read only). Each 32-bit word is two SRAM accesses, low half first. Round-robin
// grant when both ports request.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mem_req/we/addr/wdata -> rdata/ack data port; inputs held until ack
//   mem_busy                          mem_req & ~mem_ack, for pipeline freeze
//   if_req/addr -> if_rdata/if_ack    instruction port
//   if_busy                           if_req & ~if_ack
//   SRAM_DQ, SRAM_ADDR, SRAM_*_N      external SRAM interface
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_busy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_busy,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  state_t               state_q, state_d;
  port_t                grant_q, grant_d;
  port_t                last_grant_q, last_grant_d;
  logic                 we_q, we_d;
  logic [SramWordW-1:0] word_q, word_d;
  logic [15:0]          wdata_hi_q, wdata_hi_d;
  logic [15:0]          lo_buf_q, lo_buf_d;
  logic [31:0]          mem_rdata_q, mem_rdata_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic                 mem_ack_q, mem_ack_d;
  logic                 if_ack_q, if_ack_d;

  logic                 seq_start;
  logic                 seq_we;
  logic [SramAddrW-1:0] seq_addr;
  logic [SramDataW-1:0] seq_wdata;
  logic                 seq_done;
  logic [SramDataW-1:0] seq_rdata;
  logic [SramDataW-1:0] seq_dq_out;
  logic                 seq_dq_oe;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    word_d       = word_q;
    wdata_hi_d   = wdata_hi_q;
    lo_buf_d     = lo_buf_q;
    mem_rdata_d  = mem_rdata_q;
    if_rdata_d   = if_rdata_q;
    mem_ack_d    = 1'b0;
    if_ack_d     = 1'b0;
    // Default sequencer request is the high half of the latched word.
    seq_start    = 1'b0;
    seq_we       = we_q;
    seq_addr     = {word_q, 1'b1};
    seq_wdata    = wdata_hi_q;

    unique case (state_q)
      StIdle: begin
        if (mem_req || if_req) begin
          if (mem_req && if_req) begin
            grant_d = (last_grant_q == PortMem) ? PortIf : PortMem;
          end else if (mem_req) begin
            grant_d = PortMem;
          end else begin
            grant_d = PortIf;
          end
          we_d       = (grant_d == PortMem) && mem_we;
          word_d     = byte_to_word((grant_d == PortMem) ? mem_addr : if_addr, ADDR_BASE);
          wdata_hi_d = mem_wdata[31:16];
          seq_start  = 1'b1;
          seq_we     = we_d;
          seq_addr   = {word_d, 1'b0};
          seq_wdata  = mem_wdata[15:0];
          state_d    = StLo;
        end
      end
      StLo: begin
        if (seq_done) begin
          lo_buf_d  = seq_rdata;
          seq_start = 1'b1;
          state_d   = StHi;
        end
      end
      StHi: begin
        if (seq_done) begin
          state_d = StDone;
          if (grant_q == PortMem) begin
            mem_ack_d = 1'b1;
            if (!we_q) mem_rdata_d = {seq_rdata, lo_buf_q};
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = {seq_rdata, lo_buf_q};
          end
        end
      end
      StDone: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= PortMem;
      last_grant_q <= PortIf;  // data port wins the first tie
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_hi_q   <= '0;
      lo_buf_q     <= '0;
      mem_rdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_ack_q    <= 1'b0;
      if_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      word_q       <= word_d;
      wdata_hi_q   <= wdata_hi_d;
      lo_buf_q     <= lo_buf_d;
      mem_rdata_q  <= mem_rdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_ack_q    <= mem_ack_d;
      if_ack_q     <= if_ack_d;
    end
  end

  sram_half_seq #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_half_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (seq_start),
    .we_i       (seq_we),
    .addr_i     (seq_addr),
    .wdata16_i  (seq_wdata),
    .done_o     (seq_done),
    .rdata16_o  (seq_rdata),
    .sram_addr_o(SRAM_ADDR),
    .sram_ce_n_o(SRAM_CE_N),
    .sram_ub_n_o(SRAM_UB_N),
    .sram_lb_n_o(SRAM_LB_N),
    .sram_we_n_o(SRAM_WE_N),
    .sram_oe_n_o(SRAM_OE_N),
    .dq_o       (seq_dq_out),
    .dq_oe_o    (seq_dq_oe),
    .dq_i       (SRAM_DQ)
  );

  assign SRAM_DQ   = seq_dq_oe ? seq_dq_out : 16'hzzzz;
  assign mem_rdata = mem_rdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign if_ack    = if_ack_q;
  assign mem_busy  = mem_req & ~mem_ack_q;
  assign if_busy   = if_req & ~if_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the data bus, per-port scoreboards of
// expected read data and ack cycle, checked whenever an ack appears.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, if_req;
  logic [31:0] mem_addr, mem_wdata, if_addr;
  logic [31:0] mem_rdata, if_rdata;
  logic        mem_ack, mem_busy, if_ack, if_busy;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        mem_sb[$];
  exp_t        if_sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] sram_mem [0:262143];
  int          mem_n, if_n;

  sram_arbiter #(
    .WAIT_CYCLES(2),
    .ADDR_BASE  (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_busy (mem_busy),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .if_busy  (if_busy),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n),
    .SRAM_WE_N(sram_we_n),
    .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural SRAM: reads while selected with OE_N low, writes on clocks with WE_N low.
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

  initial begin : sram_model
    logic [31:0] w;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    sram_mem[18'h400] = 16'hbeef;
    sram_mem[18'h401] = 16'hcafe;
    for (int a = 32'h1000; a < 32'h1040; a += 4) begin
      w = pat(a);
      sram_mem[18'((a >> 2) * 2)]     = w[15:0];
      sram_mem[18'((a >> 2) * 2 + 1)] = w[31:16];
    end
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;
    end
  end

  // Ack monitor: every ack must match the oldest expectation for that port.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        if (mem_sb.size() == 0) begin
          check_eq("mem_ack_unexpected", 32'(mem_ack), 32'h0);
        end else begin
          e = mem_sb.pop_front();
          check_eq("mem_ack_cycle", cyc, e.cyc);
          check_eq("mem_rdata", mem_rdata, e.rdata);
        end
      end
      if (if_ack) begin
        if (if_sb.size() == 0) begin
          check_eq("if_ack_unexpected", 32'(if_ack), 32'h0);
        end else begin
          e = if_sb.pop_front();
          check_eq("if_ack_cycle", cyc, e.cyc);
          check_eq("if_rdata", if_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int c;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; if_req = 1'b0;
    mem_addr = '0; mem_wdata = '0; if_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ce_n", 32'(sram_ce_n), 32'h1);
    check_eq("rst_we_n", 32'(sram_we_n), 32'h1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 32'h1);
    check_eq("rst_ub_lb_n", {30'h0, sram_ub_n, sram_lb_n}, 32'h3);
    check_eq("rst_addr", 32'(sram_addr), 32'h0);
    check_eq("rst_acks", {30'h0, mem_ack, if_ack}, 32'h0);
    check_eq("rst_rdata", mem_rdata | if_rdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: data write, per-cycle SRAM strobes.
    c = cyc;
    mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h12345678; mem_req = 1'b1;
    mem_sb.push_back('{32'h0, c + 5});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check_eq("t1_addr", 32'(sram_addr), (k <= 2) ? 32'h200 : 32'h201);
        check_eq("t1_dq", 32'(sram_dq), (k <= 2) ? 32'h5678 : 32'h1234);
        check_eq("t1_we_n", 32'(sram_we_n), (k == 1 || k == 3) ? 32'h0 : 32'h1);
        check_eq("t1_ce_oe", {30'h0, sram_ce_n, sram_oe_n}, 32'h1);
        check_eq("t1_busy", 32'(mem_busy), 32'h1);
      end else begin
        check_eq("t1_idle_strobes", {29'h0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
        check_eq("t1_busy_ack", 32'(mem_busy), 32'h0);
      end
    end
    mem_req = 1'b0; mem_we = 1'b0;
    check_eq("t1_sram_lo", 32'(sram_mem[18'h200]), 32'h5678);
    check_eq("t1_sram_hi", 32'(sram_mem[18'h201]), 32'h1234);
    repeat (2) @(negedge clk);

    // 2: instruction read of the word just written.
    c = cyc;
    if_addr = 32'h400; if_req = 1'b1;
    if_sb.push_back('{32'h12345678, c + 5});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check_eq("t2_oe_n", 32'(sram_oe_n), 32'h0);
        check_eq("t2_we_n", 32'(sram_we_n), 32'h1);
        check_eq("t2_addr", 32'(sram_addr), (k <= 2) ? 32'h200 : 32'h201);
        check_eq("t2_dq", 32'(sram_dq), (k <= 2) ? 32'h5678 : 32'h1234);
      end
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // 3: simultaneous requests right after reset; data port first.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t3_rst_if_rdata", if_rdata, 32'h0);
    c = cyc;
    mem_we = 1'b0; mem_addr = 32'h400; mem_req = 1'b1;
    if_addr = 32'h800; if_req = 1'b1;
    mem_sb.push_back('{32'h12345678, c + 5});
    if_sb.push_back('{32'hcafebeef, c + 11});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) check_eq("t3_busy_both", {30'h0, mem_busy, if_busy}, 32'h3);
      if (k == 5) begin
        check_eq("t3_busy_at_mem_ack", {30'h0, mem_busy, if_busy}, 32'h1);
        mem_req = 1'b0;
      end
      if (k == 8) check_eq("t3_if_busy_wait", 32'(if_busy), 32'h1);
      if (k == 11) check_eq("t3_if_busy_ack", 32'(if_busy), 32'h0);
    end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t3_drain", 32'(mem_sb.size() + if_sb.size()), 32'h0);

    // 4: both held continuously; strict alternation starting with the data port.
    c = cyc; mem_n = 0; if_n = 0;
    mem_addr = 32'h1000; mem_req = 1'b1;
    if_addr = 32'h100c; if_req = 1'b1;
    mem_sb.push_back('{pat(32'h1000), c + 5});
    if_sb.push_back('{pat(32'h100c), c + 11});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_ack && mem_req) begin
        mem_n++;
        if (mem_n < 3) begin
          mem_addr = 32'h1000 + 32'(4 * mem_n);
          mem_sb.push_back('{pat(mem_addr), c + 5 + 12 * mem_n});
        end else begin
          mem_req = 1'b0;
        end
      end
      if (if_ack && if_req) begin
        if_n++;
        if (if_n < 3) begin
          if_addr = 32'h100c + 32'(4 * if_n);
          if_sb.push_back('{pat(if_addr), c + 11 + 12 * if_n});
        end else begin
          if_req = 1'b0;
        end
      end
    end
    check_eq("t4_served", 32'(mem_n + if_n), 32'h6);
    check_eq("t4_drain", 32'(mem_sb.size() + if_sb.size()), 32'h0);
    repeat (2) @(negedge clk);

    // 5: reset during the high half of a write.
    c = cyc;
    mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'haaaa5555; mem_req = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t5_hi_last_we_n", {30'h0, sram_ce_n, sram_we_n}, 32'h1);
    check_eq("t5_hi_addr", 32'(sram_addr), 32'h1001);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check_eq("t5_strobes", {27'h0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
             32'h1f);
    check_eq("t5_no_ack", 32'(mem_ack), 32'h0);
    check_eq("t5_rdata_clr", mem_rdata, 32'h0);
    rst = 1'b0;
    check_eq("t5_lo_written", 32'(sram_mem[18'h1000]), 32'h5555);
    @(negedge clk);
    c = cyc;
    mem_addr = 32'h1004; mem_req = 1'b1;
    mem_sb.push_back('{pat(32'h1004), c + 5});
    repeat (5) @(negedge clk);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);

    // 6: data request arrives while an instruction read is in flight.
    c = cyc;
    if_addr = 32'h800; if_req = 1'b1;
    if_sb.push_back('{32'hcafebeef, c + 5});
    repeat (2) @(negedge clk);
    mem_addr = 32'h1008; mem_req = 1'b1;
    mem_sb.push_back('{pat(32'h1008), c + 11});
    for (int k = 3; k <= 11; k++) begin
      @(negedge clk);
      if (k == 4) check_eq("t6_mem_busy_wait", 32'(mem_busy), 32'h1);
      if (k == 5) if_req = 1'b0;
      if (k == 11) check_eq("t6_mem_busy_ack", 32'(mem_busy), 32'h0);
    end
    mem_req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_drain", 32'(mem_sb.size() + if_sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
